// File: rtl/fir_result_fifo.sv
// ---------------------------------------------------------------------------
// fir_result_fifo
//
// Downstream capture stage for the FIR filter core. Each rising edge of the
// FIR's result strobe (fir_ready) captures one 32-bit fp32 result (fir_out)
// into a circular FIFO. The FIFO drains first-word-fall-through over a
// valid/ready stream. fir_stop back-pressures the FIR when the number of free
// entries drops to STOP_MARGIN or below.
//
// Parameters:
//   DEPTH        FIFO entries, power of 2, >= 4
//   STOP_MARGIN  fir_stop asserts when free entries <= STOP_MARGIN (1..DEPTH-1)
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   fir_ready  result-valid strobe from FIR (captured on its rising edge)
//   fir_out    FIR result, passed bit-exact
//   fir_stop   registered back-pressure to the FIR stop input
//   m_valid    head entry available
//   m_ready    consumer accepts head
//   m_data     head entry (don't-care while m_valid = 0)
//   count      current occupancy, 0..DEPTH
//   overflow   sticky: a captured result was dropped because the FIFO was full
//   nan_seen   sticky: an accepted result had an all-ones exponent (NaN/Inf)
//   nan_count  saturating count of accepted NaN/Inf results
//
// Optional feature macro: FIR_RES_NAN_FLAG_EN
//   When defined, nan_seen and nan_count (ports and logic) are present.
//   When undefined, they are absent and all other behaviour is identical.
// ---------------------------------------------------------------------------
module fir_result_fifo #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned STOP_MARGIN = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fir_ready,
    input  logic [31:0]              fir_out,
    output logic                     fir_stop,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [31:0]              m_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef FIR_RES_NAN_FLAG_EN
    ,
    output logic                     nan_seen,
    output logic [7:0]               nan_count
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [CntW-1:0] DepthCnt  = CntW'(DEPTH);
    localparam logic [CntW-1:0] MarginCnt = CntW'(STOP_MARGIN);

    // State
    logic              fir_ready_q, fir_ready_d;
    logic [PtrW-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [CntW-1:0]   count_q,     count_d;
    logic              fir_stop_q,  fir_stop_d;
    logic              overflow_q,  overflow_d;

    // Storage, intentionally not reset
    logic [31:0]       mem [DEPTH];

    // Events
    logic              cap;
    logic              pop;
    logic              full;
    logic              wr_en;
    logic              drop;

`ifdef FIR_RES_NAN_FLAG_EN
    logic              nan_seen_q,  nan_seen_d;
    logic [7:0]        nan_count_q, nan_count_d;
    logic              nonfinite;
`endif

    // -----------------------------------------------------------------------
    // Event decode and next-state
    // -----------------------------------------------------------------------
    always_comb begin
        // Rising edge of the FIR strobe: a held level captures only once.
        cap   = fir_ready & ~fir_ready_q;
        pop   = (count_q != '0) & m_ready;
        full  = (count_q == DepthCnt);
        // When full, a same-cycle pop frees the head slot for the new write.
        wr_en = cap & (~full | pop);
        drop  = cap & full & ~pop;

        fir_ready_d = fir_ready;

        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        count_d = count_q;
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q | drop;

        // Based on post-update occupancy so fir_stop tracks count exactly.
        fir_stop_d = (DepthCnt - count_d) <= MarginCnt;
    end

`ifdef FIR_RES_NAN_FLAG_EN
    always_comb begin
        // All-ones exponent covers both NaN and +/-Inf.
        nonfinite   = (fir_out[30:23] == 8'hFF);
        nan_seen_d  = nan_seen_q;
        nan_count_d = nan_count_q;
        // Dropped samples are never inspected, only accepted writes.
        if (wr_en && nonfinite) begin
            nan_seen_d = 1'b1;
            if (nan_count_q != 8'hFF) begin
                nan_count_d = nan_count_q + 8'd1;
            end
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fir_ready_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fir_stop_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            fir_ready_q <= fir_ready_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fir_stop_q  <= fir_stop_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef FIR_RES_NAN_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            nan_seen_q  <= 1'b0;
            nan_count_q <= 8'd0;
        end else begin
            nan_seen_q  <= nan_seen_d;
            nan_count_q <= nan_count_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Storage write port
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr_q] <= fir_out;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: first-word-fall-through head read from the registered pointer
    // -----------------------------------------------------------------------
    assign m_valid  = (count_q != '0);
    assign m_data   = mem[rd_ptr_q];
    assign count    = count_q;
    assign fir_stop = fir_stop_q;
    assign overflow = overflow_q;

`ifdef FIR_RES_NAN_FLAG_EN
    assign nan_seen  = nan_seen_q;
    assign nan_count = nan_count_q;
`endif

endmodule

// File: tb/tb_fir_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_fir_result_fifo
//
// Self-checking bench for fir_result_fifo (DEPTH=16, STOP_MARGIN=2).
// Expected head values come from a queue scoreboard filled as results are
// driven; occupancy, fir_stop, overflow (and NaN flags with
// FIR_RES_NAN_FLAG_EN) come from a small reference model.
// ---------------------------------------------------------------------------
module tb_fir_result_fifo;

    localparam int unsigned DEPTH       = 16;
    localparam int unsigned STOP_MARGIN = 2;
    localparam int unsigned CW          = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          fir_ready;
    logic [31:0]   fir_out;
    logic          fir_stop;
    logic          m_valid;
    logic          m_ready;
    logic [31:0]   m_data;
    logic [CW-1:0] count;
    logic          overflow;
`ifdef FIR_RES_NAN_FLAG_EN
    logic          nan_seen;
    logic [7:0]    nan_count;
`endif

    fir_result_fifo #(
        .DEPTH       (DEPTH),
        .STOP_MARGIN (STOP_MARGIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fir_ready (fir_ready),
        .fir_out   (fir_out),
        .fir_stop  (fir_stop),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .count     (count),
        .overflow  (overflow)
`ifdef FIR_RES_NAN_FLAG_EN
        ,
        .nan_seen  (nan_seen),
        .nan_count (nan_count)
`endif
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb[$];
    logic        m_ovf;
    logic        m_nan_seen;
    int          m_nan_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    // Advance one clock; sample 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sb.delete();
        m_ovf      = 1'b0;
        m_nan_seen = 1'b0;
        m_nan_cnt  = 0;
    endtask

    // Model a capture with m_ready low: accept if room, else drop.
    task automatic model_cap(input logic [31:0] d);
        if (sb.size() < DEPTH) begin
            sb.push_back(d);
            if (d[30:23] == 8'hFF) begin
                m_nan_seen = 1'b1;
                if (m_nan_cnt < 255) m_nan_cnt++;
            end
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic chk_state(input string tag);
        int unsigned n;
        n = sb.size();
        chk({tag, ".count"},    32'(count),    32'(n));
        chk({tag, ".m_valid"},  32'(m_valid),  32'(n != 0));
        chk({tag, ".fir_stop"}, 32'(fir_stop), 32'((DEPTH - n) <= STOP_MARGIN));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        if (n != 0) chk({tag, ".m_data"}, m_data, sb[0]);
`ifdef FIR_RES_NAN_FLAG_EN
        chk({tag, ".nan_seen"},  32'(nan_seen),  32'(m_nan_seen));
        chk({tag, ".nan_count"}, 32'(nan_count), 32'(m_nan_cnt));
`endif
    endtask

    task automatic do_reset(input string tag);
        rst       = 1'b1;
        fir_ready = 1'b0;
        m_ready   = 1'b0;
        fir_out   = 32'h0;
        step();
        rst = 1'b0;
        model_reset();
        chk_state(tag);
    endtask

    // One-cycle strobe with m_ready low, then one low cycle to re-arm.
    task automatic pulse(input string tag, input logic [31:0] d);
        fir_ready = 1'b1;
        fir_out   = d;
        model_cap(d);
        step();
        chk_state(tag);
        fir_ready = 1'b0;
        fir_out   = ~d;
        step();
    endtask

    task automatic drain_all(input string tag);
        m_ready = 1'b1;
        while (sb.size() > 0) begin
            chk({tag, ".m_valid"}, 32'(m_valid), 32'd1);
            chk({tag, ".m_data"},  m_data,       sb[0]);
            void'(sb.pop_front());
            step();
        end
        m_ready = 1'b0;
        chk_state({tag, ".empty"});
    endtask

    initial begin
        int outs;
        int max_cnt;

        // 1. Reset, then single pulse and single pop
        do_reset("reset");
        fir_out   = 32'h3ef5580e;
        fir_ready = 1'b1;
        model_cap(32'h3ef5580e);
        step();
        fir_ready = 1'b0;
        fir_out   = 32'h0;
        chk_state("single");
        chk("single.head", m_data, 32'h3ef5580e);
        m_ready = 1'b1;
        void'(sb.pop_front());
        step();
        m_ready = 1'b0;
        chk_state("single.pop");

        // 2. Held level captures once
        fir_out   = 32'hbe825a8b;
        fir_ready = 1'b1;
        model_cap(32'hbe825a8b);
        repeat (5) step();
        fir_ready = 1'b0;
        step();
        chk_state("held");
        drain_all("held.drain");

        // 3. Fill, back-pressure, overflow, in-order drain
        for (int i = 0; i < 17; i++) begin
            pulse($sformatf("fill%0d", i), 32'h4000_0000 + 32'(i));
        end
        chk("fill.overflow", 32'(overflow), 32'd1);
        drain_all("fill.drain");

        // 4. Simultaneous push/pop at full
        do_reset("rst2");
        for (int i = 0; i < 16; i++) begin
            pulse($sformatf("full%0d", i), 32'hA000_0000 + 32'(i));
        end
        fir_ready = 1'b1;
        fir_out   = 32'hC0FF_EE00;
        m_ready   = 1'b1;
        chk("pushpop.head", m_data, sb[0]);
        void'(sb.pop_front());
        sb.push_back(32'hC0FF_EE00);
        step();
        fir_ready = 1'b0;
        m_ready   = 1'b0;
        chk_state("pushpop");
        step();
        drain_all("pushpop.drain");

        // 5. Wrap-around streaming with m_ready held high
        outs    = 0;
        max_cnt = 0;
        m_ready = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            for (int ph = 0; ph < 2; ph++) begin
                fir_ready = (ph == 0);
                fir_out   = 32'(i);
                chk("stream.m_valid", 32'(m_valid), 32'(sb.size() != 0));
                if (sb.size() != 0) begin
                    chk("stream.m_data", m_data, sb[0]);
                    void'(sb.pop_front());
                    outs++;
                end
                if (ph == 0) sb.push_back(32'(i));
                step();
                chk("stream.count", 32'(count), 32'(sb.size()));
                if (int'(count) > max_cnt) max_cnt = int'(count);
            end
        end
        fir_ready = 1'b0;
        m_ready   = 1'b0;
        chk("stream.outs", 32'(outs), 32'd40);
        chk("stream.max_le2", 32'(max_cnt <= 2), 32'd1);
        chk_state("stream.end");

        // 6. Reset mid-operation
        for (int i = 0; i < 7; i++) begin
            pulse($sformatf("mid%0d", i), 32'h5000_0000 + 32'(i));
        end
        chk("mid.count7", 32'(count), 32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        chk_state("midrst");
`ifdef FIR_RES_NAN_FLAG_EN
        pulse("nan.qnan", 32'h7fc00000);
        chk("nan.seen1", 32'(nan_seen), 32'd1);
        chk("nan.cnt1", 32'(nan_count), 32'd1);
        pulse("nan.finite", 32'h3f800000);
        pulse("nan.neginf", 32'hff800000);
`else
        pulse("post.rst", 32'h7fc00000);
`endif
        drain_all("final.drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
